// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the core/load path and the register-file write-port arbiter.
interface wb_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic            core_we;
  logic [4:0]      core_rd;
  logic [XLEN-1:0] core_data;
  logic            ld_issue;
  logic [4:0]      ld_issue_rd;
  logic            ld_valid;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            ld_ready;
  logic            stall_core;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     busy_mask;

  modport master (
    output core_we, core_rd, core_data, ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_data,
    input  ld_ready, stall_core, rf_we, rf_waddr, rf_wdata, busy_mask
  );

  modport slave (
    input  core_we, core_rd, core_data, ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_data,
    output ld_ready, stall_core, rf_we, rf_waddr, rf_wdata, busy_mask
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: core writeback has priority, late load
// responses queue in a small FIFO and drain into idle slots or force a core stall.
module wb_port_arbiter #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  wb_port_arbiter_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [DEPTH-1:0][4:0]      mem_rd;
  logic [DEPTH-1:0][XLEN-1:0] mem_data;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              count, count_nxt;
  logic [WW-1:0]              wait_cnt, wait_nxt;
  logic                       stall_q, stall_nxt;
  logic                       rf_we_q;
  logic [4:0]                 rf_waddr_q;
  logic [XLEN-1:0]            rf_wdata_q;
  logic [31:0]                busy_q, busy_nxt;

  logic            core_eff, pop, push, grant;
  logic [4:0]      head_rd, g_rd;
  logic [XLEN-1:0] head_data, g_data;

  assign head_rd   = mem_rd[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  // ld_ready looks only at the registered count, so a same-cycle pop frees nothing
  assign bus.ld_ready = (count < CW'(DEPTH));
  assign push         = bus.ld_valid & bus.ld_ready;
  assign core_eff     = bus.core_we & ~stall_q;
  assign pop          = ~core_eff & (count != '0);
  assign grant        = core_eff | pop;
  assign g_rd         = core_eff ? bus.core_rd   : head_rd;
  assign g_data       = core_eff ? bus.core_data : head_data;

  always_comb begin
    count_nxt = count + CW'(push) - CW'(pop);

    wait_nxt = wait_cnt;
    if ((count == '0) || pop)            wait_nxt = '0;
    else if (wait_cnt < WW'(MAX_WAIT))   wait_nxt = wait_cnt + 1'b1;

    stall_nxt = (count_nxt == CW'(DEPTH)) |
                ((count_nxt != '0) & (wait_nxt >= WW'(MAX_WAIT)));

    // clear first so a same-register issue in this cycle wins
    busy_nxt = busy_q;
    if (pop)                                    busy_nxt[head_rd]         = 1'b0;
    if (bus.ld_issue && bus.ld_issue_rd != '0)  busy_nxt[bus.ld_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= bus.ld_rd;
      mem_data[wr_ptr] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wait_cnt   <= '0;
      stall_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count    <= count_nxt;
      wait_cnt <= wait_nxt;
      stall_q  <= stall_nxt;
      busy_q   <= busy_nxt;
      // writes to x0 are consumed but never reach the register file
      rf_we_q  <= grant & (g_rd != '0);
      if (grant) begin
        rf_waddr_q <= g_rd;
        rf_wdata_q <= g_data;
      end
    end
  end

  assign bus.stall_core = stall_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.busy_mask  = busy_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized + directed bench for wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;
  localparam int XLEN = 32, DEPTH = 2, MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.XLEN(XLEN)) bus();
  wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;

  ent_t        q[$];
  int          wait_m;
  logic        stall_m, we_m;
  logic [4:0]  addr_m;
  logic [31:0] data_m, busy_m;
  int          tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    wait_m = 0; stall_m = 0; we_m = 0; addr_m = '0; data_m = '0; busy_m = '0;
  endtask

  task automatic idle();
    bus.core_we = 0; bus.core_rd = '0; bus.core_data = '0;
    bus.ld_issue = 0; bus.ld_issue_rd = '0;
    bus.ld_valid = 0; bus.ld_rd = '0; bus.ld_data = '0;
  endtask

  task automatic check_model();
    chk("m_rf_we", bus.rf_we, we_m);
    if (we_m) begin
      chk("m_rf_waddr", bus.rf_waddr, addr_m);
      chk("m_rf_wdata", bus.rf_wdata, data_m);
    end
    chk("m_stall", bus.stall_core, stall_m);
    chk("m_busy", bus.busy_mask, busy_m);
    chk("m_ld_ready", bus.ld_ready, q.size() < DEPTH);
  endtask

  // One clock: model the edge from the current inputs, then compare on the falling edge.
  task automatic tick();
    bit          ready, ceff, pop, g;
    int          sz0, wait_n;
    logic [4:0]  grd;
    logic [31:0] gd, busy_n;
    bit          stall_n;
    sz0   = q.size();
    ready = sz0 < DEPTH;
    ceff  = bus.core_we && !stall_m;
    pop   = !ceff && sz0 != 0;
    g = 0; grd = '0; gd = '0;
    busy_n = busy_m;
    if (ceff) begin g = 1; grd = bus.core_rd; gd = bus.core_data; end
    else if (pop) begin g = 1; grd = q[0].rd; gd = q[0].data; busy_n[q[0].rd] = 1'b0; end
    if (bus.ld_issue && bus.ld_issue_rd != 0) busy_n[bus.ld_issue_rd] = 1'b1;
    busy_n[0] = 1'b0;
    if (pop) void'(q.pop_front());
    if (bus.ld_valid && ready) q.push_back('{rd: bus.ld_rd, data: bus.ld_data});
    wait_n  = (sz0 == 0 || pop) ? 0 : ((wait_m < MAX_WAIT) ? wait_m + 1 : wait_m);
    stall_n = (q.size() == DEPTH) || (q.size() != 0 && wait_n >= MAX_WAIT);
    @(posedge clk);
    wait_m = wait_n; stall_m = stall_n; busy_m = busy_n;
    we_m = g && grd != 0;
    if (g) begin addr_m = grd; data_m = gd; end
    @(negedge clk);
    check_model();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rf_we"}, bus.rf_we, 0);
    chk({tag, "_rf_waddr"}, bus.rf_waddr, 0);
    chk({tag, "_rf_wdata"}, bus.rf_wdata, 0);
    chk({tag, "_stall"}, bus.stall_core, 0);
    chk({tag, "_busy"}, bus.busy_mask, 0);
    chk({tag, "_ld_ready"}, bus.ld_ready, 1);
  endtask

  initial begin
    int pct;
    idle();
    model_reset();
    #12;
    chk_reset_outs("rst");
    @(negedge clk); rst_n = 1;
    check_model();

    // core write lands one edge later
    bus.core_we = 1; bus.core_rd = 5; bus.core_data = 32'hDEADBEEF;
    tick();
    chk("t1_we", bus.rf_we, 1); chk("t1_addr", bus.rf_waddr, 5); chk("t1_data", bus.rf_wdata, 32'hDEADBEEF);

    // late load: busy bit, FIFO latency, clear on write
    idle(); bus.ld_issue = 1; bus.ld_issue_rd = 7;
    tick();
    chk("t2_busy_set", bus.busy_mask[7], 1);
    idle(); bus.ld_valid = 1; bus.ld_rd = 7; bus.ld_data = 32'h12345678;
    tick();
    chk("t2_no_bypass", bus.rf_we, 0);
    idle();
    tick();
    chk("t2_we", bus.rf_we, 1); chk("t2_addr", bus.rf_waddr, 7);
    chk("t2_data", bus.rf_wdata, 32'h12345678); chk("t2_busy_clr", bus.busy_mask[7], 0);

    // starvation: stall on the 4th edge after the head is visible
    bus.core_we = 1; bus.core_rd = 1; bus.core_data = 32'h11;
    bus.ld_valid = 1; bus.ld_rd = 9; bus.ld_data = 32'h99;
    tick();
    bus.ld_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t3_stall_e%0d", i), bus.stall_core, (i == 4));
    end
    tick();
    chk("t3_we", bus.rf_we, 1); chk("t3_addr", bus.rf_waddr, 9); chk("t3_unstall", bus.stall_core, 0);

    // full FIFO: back-pressure, stall, in-order drain
    bus.core_we = 1; bus.core_rd = 1; bus.core_data = 32'h22;
    bus.ld_valid = 1; bus.ld_rd = 10; bus.ld_data = 32'hA0;
    tick();
    bus.ld_rd = 11; bus.ld_data = 32'hA1;
    tick();
    chk("t4_full_stall", bus.stall_core, 1); chk("t4_not_ready", bus.ld_ready, 0);
    bus.ld_rd = 12; bus.ld_data = 32'hA2;
    tick();
    chk("t4_first", bus.rf_waddr, 10); chk("t4_ready_again", bus.ld_ready, 1);
    tick();
    chk("t4_core_between", bus.rf_waddr, 1);
    bus.ld_valid = 0;
    tick();
    chk("t4_second", bus.rf_waddr, 11);
    bus.core_we = 0;
    tick();
    chk("t4_third", bus.rf_waddr, 12); chk("t4_third_data", bus.rf_wdata, 32'hA2);

    // x0 filter on both paths
    idle(); bus.core_we = 1; bus.core_rd = 0; bus.core_data = 32'h5; bus.ld_issue = 1; bus.ld_issue_rd = 0;
    tick();
    chk("t5_we", bus.rf_we, 0); chk("t5_busy", bus.busy_mask, 0);

    // mid-cycle reset with two queued responses
    idle(); bus.core_we = 1; bus.core_rd = 2; bus.ld_valid = 1; bus.ld_rd = 3;
    bus.ld_issue = 1; bus.ld_issue_rd = 3;
    tick();
    bus.ld_rd = 4; bus.ld_issue_rd = 4;
    tick();
    idle();
    @(posedge clk); #2 rst_n = 0; #1;
    chk_reset_outs("t6");
    model_reset();
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_ghost", bus.rf_we, 0);
    end

    // randomized traffic at varying core load
    for (int seg = 0; seg < 4; seg++) begin
      pct = (seg == 0) ? 50 : (seg == 1) ? 90 : (seg == 2) ? 100 : 20;
      for (int i = 0; i < 700; i++) begin
        bus.core_we     = ($urandom_range(0, 99) < pct);
        bus.core_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.core_data   = $urandom;
        bus.ld_valid    = ($urandom_range(0, 9) < 4);
        bus.ld_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.ld_data     = $urandom;
        bus.ld_issue    = ($urandom_range(0, 9) < 3);
        bus.ld_issue_rd = 5'($urandom_range(0, 31));
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
